// File: rtl/horiz_sync_chain_if.sv
// Horizontal timing bus from horiz_sync_chain to the vertical chain and pixel fetch.
// With COMPSYNC_EN defined the bus also carries VSYNC_IN and COMPSYNCn.
interface horiz_sync_chain_if;
   logic       PIXCE;
   logic [8:0] hcount;
   logic       HBLANK;
   logic       HSYNC;
   logic       LINE_ST;
`ifdef COMPSYNC_EN
   logic       VSYNC_IN;
   logic       COMPSYNCn;
`endif

   modport master (
      output PIXCE,
      output hcount,
      output HBLANK,
      output HSYNC,
      output LINE_ST
`ifdef COMPSYNC_EN
      ,
      input  VSYNC_IN,
      output COMPSYNCn
`endif
   );

   modport slave (
      input  PIXCE,
      input  hcount,
      input  HBLANK,
      input  HSYNC,
      input  LINE_ST
`ifdef COMPSYNC_EN
      ,
      output VSYNC_IN,
      input  COMPSYNCn
`endif
   );
endinterface

// File: rtl/horiz_sync_chain.sv
// Horizontal video timing from CLK10: pixel enable, pixel count, HBLANK/HSYNC, line strobe.
// Define COMPSYNC_EN to add the composite sync output (VSYNC_IN in, COMPSYNCn out).
module horiz_sync_chain #(
   parameter int unsigned H_TOTAL     = 320,
   parameter int unsigned H_VISIBLE   = 256,
   parameter int unsigned HSYNC_START = 272,
   parameter int unsigned HSYNC_WIDTH = 32
) (
   input logic                CLK10,
   input logic                RESET,
   horiz_sync_chain_if.master bus
);
   localparam int unsigned HC_W = 9;
   localparam int unsigned CW   = HC_W + 1;

   localparam logic [HC_W-1:0] H_LAST   = HC_W'(H_TOTAL - 1);
   localparam logic [CW-1:0]   VIS_C    = CW'(H_VISIBLE);
   localparam logic [CW-1:0]   HS_BEG_C = CW'(HSYNC_START);
   localparam logic [CW-1:0]   HS_END_C = CW'(HSYNC_START + HSYNC_WIDTH);

   // Blank and sync window must fit inside the line.
   if (H_TOTAL == 0 || H_TOTAL > 512 || H_VISIBLE > HSYNC_START ||
       HSYNC_START + HSYNC_WIDTH > H_TOTAL) begin : g_cfg_err
      $error("horiz_sync_chain: illegal timing parameters");
   end

   logic            ph_q, ph_d;
   logic [HC_W-1:0] hcount_q, hcount_d;
   logic            hblank_q, hblank_d;
   logic            hsync_q, hsync_d;
   logic            line_st_q, line_st_d;
   logic [CW-1:0]   hcount_ext;

   // Decodes look at the next count so they line up with hcount with no lag.
   always_comb begin
      ph_d       = ~ph_q;
      hcount_d   = hcount_q;
      line_st_d  = 1'b0;
      if (ph_q) begin
         if (hcount_q == H_LAST) begin
            hcount_d  = '0;
            line_st_d = 1'b1;
         end else begin
            hcount_d = HC_W'(hcount_q + HC_W'(1));
         end
      end
      hcount_ext = {1'b0, hcount_d};
      hblank_d   = (hcount_ext >= VIS_C);
      hsync_d    = (hcount_ext >= HS_BEG_C) && (hcount_ext < HS_END_C);
   end

   always_ff @(posedge CLK10) begin
      if (RESET) begin
         ph_q      <= 1'b0;
         hcount_q  <= '0;
         hblank_q  <= 1'b0;
         hsync_q   <= 1'b0;
         line_st_q <= 1'b0;
      end else begin
         ph_q      <= ph_d;
         hcount_q  <= hcount_d;
         hblank_q  <= hblank_d;
         hsync_q   <= hsync_d;
         line_st_q <= line_st_d;
      end
   end

   assign bus.PIXCE   = ph_q;
   assign bus.hcount  = hcount_q;
   assign bus.HBLANK  = hblank_q;
   assign bus.HSYNC   = hsync_q;
   assign bus.LINE_ST = line_st_q;

`ifdef COMPSYNC_EN
   logic compsync_q, compsync_d;

   // Active-low composite sync: HSYNC inverted while VSYNC_IN is high.
   always_comb begin
      compsync_d = ~(hsync_d ^ bus.VSYNC_IN);
   end

   always_ff @(posedge CLK10) begin
      if (RESET) begin
         compsync_q <= 1'b1;
      end else begin
         compsync_q <= compsync_d;
      end
   end

   assign bus.COMPSYNCn = compsync_q;
`endif
endmodule

// File: tb/tb_horiz_sync_chain.sv
// Bench for horiz_sync_chain: default-timing and 400-pixel-line instances against a cycle-count model.
module tb_horiz_sync_chain;
   typedef struct packed {
      logic       pixce;
      logic [8:0] hc;
      logic       hb;
      logic       hs;
      logic       ls;
      logic       cs;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;
   int   k = 0;
   exp_t q_a[$];
   exp_t q_b[$];

   int   len_a = 0, hb_a = 0, hs_a = 0, lines_a = 0, last_len_a = 0, last_hb_a = 0, last_hs_a = 0;
   int   len_b = 0, hb_b = 0, hs_b = 0, lines_b = 0, last_len_b = 0, last_hb_b = 0, last_hs_b = 0;
   bit   seen_a = 0, seen_b = 0;

   always #5 clk = ~clk;

   horiz_sync_chain_if if_a ();
   horiz_sync_chain_if if_b ();

   horiz_sync_chain dut_a (.CLK10(clk), .RESET(rst), .bus(if_a));
   horiz_sync_chain #(.H_TOTAL(400), .H_VISIBLE(320), .HSYNC_START(340), .HSYNC_WIDTH(20))
      dut_b (.CLK10(clk), .RESET(rst), .bus(if_b));

   // Expected outputs kk edges after the last reset edge (kk=0 is the reset edge itself).
   function automatic exp_t model(input int kk, input int ht, input int hv, input int hss,
                                  input int hsw, input logic v);
      exp_t e;
      int   hc;
      e    = '0;
      e.cs = 1'b1;
      if (kk != 0) begin
         hc      = (kk / 2) % ht;
         e.pixce = (kk % 2 == 1);
         e.hc    = 9'(hc);
         e.hb    = (hc >= hv);
         e.hs    = (hc >= hss) && (hc < hss + hsw);
         e.ls    = (kk % 2 == 0) && (hc == 0);
         e.cs    = ~(e.hs ^ v);
      end
      return e;
   endfunction

   task automatic step(input logic r, input logic v);
      int k_next;
      rst = r;
`ifdef COMPSYNC_EN
      if_a.VSYNC_IN = v;
      if_b.VSYNC_IN = v;
`endif
      k_next = r ? 0 : k + 1;
      q_a.push_back(model(k_next, 320, 256, 272, 32, v));
      q_b.push_back(model(k_next, 400, 320, 340, 20, v));
      @(posedge clk);
      #2;
      k = k_next;
   endtask

   // Scoreboard consumer plus per-line measurement of the DUT outputs.
   always @(posedge clk) begin
      exp_t ea, eb;
      #1;
      if (q_a.size() > 0) begin
         ea = q_a.pop_front();
         checks++;
         if ({if_a.PIXCE, if_a.hcount, if_a.HBLANK, if_a.HSYNC, if_a.LINE_ST} !==
             {ea.pixce, ea.hc, ea.hb, ea.hs, ea.ls}) begin
            errors++;
            $display("FAIL sb_a t=%0t got px=%b hc=%0d hb=%b hs=%b ls=%b want px=%b hc=%0d hb=%b hs=%b ls=%b",
                     $time, if_a.PIXCE, if_a.hcount, if_a.HBLANK, if_a.HSYNC, if_a.LINE_ST,
                     ea.pixce, ea.hc, ea.hb, ea.hs, ea.ls);
         end
`ifdef COMPSYNC_EN
         checks++;
         if (if_a.COMPSYNCn !== ea.cs) begin
            errors++;
            $display("FAIL compsync_a t=%0t got %b want %b", $time, if_a.COMPSYNCn, ea.cs);
         end
`endif
         if (rst) seen_a = 0;
         else begin
            if (if_a.LINE_ST === 1'b1) begin
               if (seen_a) begin
                  last_len_a = len_a; last_hb_a = hb_a; last_hs_a = hs_a; lines_a++;
               end
               seen_a = 1; len_a = 0; hb_a = 0; hs_a = 0;
            end
            if (seen_a) begin
               len_a++;
               if (if_a.HBLANK === 1'b1) hb_a++;
               if (if_a.HSYNC === 1'b1) hs_a++;
            end
         end
      end
      if (q_b.size() > 0) begin
         eb = q_b.pop_front();
         checks++;
         if ({if_b.PIXCE, if_b.hcount, if_b.HBLANK, if_b.HSYNC, if_b.LINE_ST} !==
             {eb.pixce, eb.hc, eb.hb, eb.hs, eb.ls}) begin
            errors++;
            $display("FAIL sb_b t=%0t got px=%b hc=%0d hb=%b hs=%b ls=%b want px=%b hc=%0d hb=%b hs=%b ls=%b",
                     $time, if_b.PIXCE, if_b.hcount, if_b.HBLANK, if_b.HSYNC, if_b.LINE_ST,
                     eb.pixce, eb.hc, eb.hb, eb.hs, eb.ls);
         end
`ifdef COMPSYNC_EN
         checks++;
         if (if_b.COMPSYNCn !== eb.cs) begin
            errors++;
            $display("FAIL compsync_b t=%0t got %b want %b", $time, if_b.COMPSYNCn, eb.cs);
         end
`endif
         if (rst) seen_b = 0;
         else begin
            if (if_b.LINE_ST === 1'b1) begin
               if (seen_b) begin
                  last_len_b = len_b; last_hb_b = hb_b; last_hs_b = hs_b; lines_b++;
               end
               seen_b = 1; len_b = 0; hb_b = 0; hs_b = 0;
            end
            if (seen_b) begin
               len_b++;
               if (if_b.HBLANK === 1'b1) hb_b++;
               if (if_b.HSYNC === 1'b1) hs_b++;
            end
         end
      end
   end

   task automatic test_reset();
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b0);
         checks++;
         if ({if_a.PIXCE, if_a.hcount, if_a.HBLANK, if_a.HSYNC, if_a.LINE_ST} !== 13'd0) begin
            errors++;
            $display("FAIL reset_zero got %b want 0",
                     {if_a.PIXCE, if_a.hcount, if_a.HBLANK, if_a.HSYNC, if_a.LINE_ST});
         end
      end
      step(1'b0, 1'b0);
      checks++;
      if (if_a.PIXCE !== 1'b1) begin
         errors++;
         $display("FAIL first_pixce got %b want 1", if_a.PIXCE);
      end
      step(1'b0, 1'b0);
      checks++;
      if (if_a.hcount !== 9'd1 || if_a.PIXCE !== 1'b0) begin
         errors++;
         $display("FAIL second_edge got hc=%0d px=%b want hc=1 px=0", if_a.hcount, if_a.PIXCE);
      end
   endtask

   task automatic test_free_run();
      for (int i = 0; i < 1700; i++) step(1'b0, 1'b0);
      checks++;
      if (lines_a < 1 || last_len_a != 640 || last_hb_a != 128 || last_hs_a != 64) begin
         errors++;
         $display("FAIL line_a got lines=%0d len=%0d hb=%0d hs=%0d want >=1 640 128 64",
                  lines_a, last_len_a, last_hb_a, last_hs_a);
      end
      checks++;
      if (lines_b < 1 || last_len_b != 800 || last_hb_b != 160 || last_hs_b != 40) begin
         errors++;
         $display("FAIL line_b got lines=%0d len=%0d hb=%0d hs=%0d want >=1 800 160 40",
                  lines_b, last_len_b, last_hb_b, last_hs_b);
      end
   endtask

   task automatic test_mid_reset();
      bit found = 0;
      for (int i = 0; i < 700 && !found; i++) begin
         if (if_a.hcount === 9'd290) found = 1;
         else step(1'b0, 1'b0);
      end
      checks++;
      if (!found || if_a.HBLANK !== 1'b1 || if_a.HSYNC !== 1'b1) begin
         errors++;
         $display("FAIL reach_290 got found=%0d hb=%b hs=%b want 1 1 1", found, if_a.HBLANK, if_a.HSYNC);
      end
      step(1'b1, 1'b0);
      checks++;
      if ({if_a.PIXCE, if_a.hcount, if_a.HBLANK, if_a.HSYNC, if_a.LINE_ST} !== 13'd0) begin
         errors++;
         $display("FAIL mid_reset got %b want 0",
                  {if_a.PIXCE, if_a.hcount, if_a.HBLANK, if_a.HSYNC, if_a.LINE_ST});
      end
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      checks++;
      if (if_a.hcount !== 9'd1 || if_a.PIXCE !== 1'b0) begin
         errors++;
         $display("FAIL restart_phase got hc=%0d px=%b want hc=1 px=0", if_a.hcount, if_a.PIXCE);
      end
      for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
   endtask

`ifdef COMPSYNC_EN
   task automatic test_compsync();
      bit found = 0;
      for (int i = 0; i < 650; i++) step(1'b0, 1'b0);
      for (int i = 0; i < 700 && !found; i++) begin
         if (if_a.hcount === 9'd280) found = 1;
         else step(1'b0, 1'b0);
      end
      checks++;
      if (!found || if_a.COMPSYNCn !== 1'b0) begin
         errors++;
         $display("FAIL cs_in_hsync got found=%0d cs=%b want 1 0", found, if_a.COMPSYNCn);
      end
      step(1'b0, 1'b1);
      for (int i = 0; i < 700; i++) step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      checks++;
      if (if_a.COMPSYNCn !== 1'b1) begin
         errors++;
         $display("FAIL cs_reset got %b want 1", if_a.COMPSYNCn);
      end
      step(1'b0, 1'b0);
   endtask
`endif

   initial begin
      rst = 1'b1;
`ifdef COMPSYNC_EN
      if_a.VSYNC_IN = 1'b0;
      if_b.VSYNC_IN = 1'b0;
`endif
      test_reset();
      test_free_run();
      test_mid_reset();
`ifdef COMPSYNC_EN
      test_compsync();
`endif
      #20;
      checks++;
      if (q_a.size() != 0 || q_b.size() != 0) begin
         errors++;
         $display("FAIL sb_drain got a=%0d b=%0d want 0 0", q_a.size(), q_b.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
